regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_bypass.sv | 42 ++++
 rtl/regfile_mp.sv | 77 +++++++
 tb/tb_regfile_mp.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: default geometry and
// the hardwired-zero register index.
package regfile_pkg;
  localparam int DEF_DW   = 32;
  localparam int DEF_AW   = 5;
  localparam int DEF_NRD  = 2;
  localparam int DEF_NWR  = 2;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/regfile_bypass.sv
// One read port: write-first forwarding over all write ports (highest port
// wins), busy masking for same-cycle writes, and register-0 forcing.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int AW  = DEF_AW,
  parameter int NWR = DEF_NWR
) (
  input  logic [AW-1:0]     raddr,
  input  logic [DW-1:0]     mem_word,
  input  logic              busy,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic [NWR*DW-1:0] wdata,
  output logic [DW-1:0]     rdata,
  output logic              rbusy
);

  logic          hit;
  logic [DW-1:0] fwd;

  always_comb begin
    hit = 1'b0;
    fwd = mem_word;
    // Ascending scan so the highest-indexed matching port is the last to assign.
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && (waddr[j*AW +: AW] == raddr)) begin
        hit = 1'b1;
        fwd = wdata[j*DW +: DW];
      end
    end
    if (raddr == AW'(ZERO_REG)) begin
      rdata = '0;
      rbusy = 1'b0;
    end else begin
      rdata = fwd;
      rbusy = busy & ~hit;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-first bypass and a per-register
// pending-write scoreboard for hazard detection in decode.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int AW  = DEF_AW,
  parameter int NRD = DEF_NRD,
  parameter int NWR = DEF_NWR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic [NWR*DW-1:0] wdata,
  input  logic              rsv_we,
  input  logic [AW-1:0]     rsv_addr
);

  localparam int NREG = 2 ** AW;

  logic [DW-1:0]   mem_q [NREG];
  logic [DW-1:0]   mem_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && (waddr[j*AW +: AW] != AW'(ZERO_REG))) begin
        mem_d[waddr[j*AW +: AW]]  = wdata[j*DW +: DW];
        busy_d[waddr[j*AW +: AW]] = 1'b0;
      end
    end
    // Applied after the writes: a new producer supersedes a completing one.
    if (rsv_we && (rsv_addr != AW'(ZERO_REG))) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) begin
        mem_q[k] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[i*AW +: AW];

    regfile_bypass #(
      .DW  (DW),
      .AW  (AW),
      .NWR (NWR)
    ) u_byp (
      .raddr    (ra),
      .mem_word (mem_q[ra]),
      .busy     (busy_q[ra]),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .rdata    (rdata[i*DW +: DW]),
      .rbusy    (rbusy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed scenarios on the default
// geometry and random traffic on a 4-read/1-write/64-bit/16-entry instance.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default geometry instance (DW=32, AW=5, NRD=2, NWR=2)
  logic [9:0]  raddr_a;
  logic [63:0] rdata_a;
  logic [1:0]  rbusy_a;
  logic [1:0]  we_a;
  logic [9:0]  waddr_a;
  logic [63:0] wdata_a;
  logic        rsv_we_a;
  logic [4:0]  rsv_addr_a;

  regfile_mp u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .raddr    (raddr_a),
    .rdata    (rdata_a),
    .rbusy    (rbusy_a),
    .we       (we_a),
    .waddr    (waddr_a),
    .wdata    (wdata_a),
    .rsv_we   (rsv_we_a),
    .rsv_addr (rsv_addr_a)
  );

  // Swept geometry instance (DW=64, AW=4, NRD=4, NWR=1)
  logic [15:0]  raddr_b;
  logic [255:0] rdata_b;
  logic [3:0]   rbusy_b;
  logic [0:0]   we_b;
  logic [3:0]   waddr_b;
  logic [63:0]  wdata_b;
  logic         rsv_we_b;
  logic [3:0]   rsv_addr_b;

  regfile_mp #(.DW(64), .AW(4), .NRD(4), .NWR(1)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .raddr    (raddr_b),
    .rdata    (rdata_b),
    .rbusy    (rbusy_b),
    .we       (we_b),
    .waddr    (waddr_b),
    .wdata    (wdata_b),
    .rsv_we   (rsv_we_b),
    .rsv_addr (rsv_addr_b)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] ma [32];
  logic        ba [32];
  logic [63:0] mb [16];
  logic        bb [16];

  logic [63:0] q_data [$];
  logic        q_busy [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_a();
    raddr_a = '0; we_a = '0; waddr_a = '0; wdata_a = '0;
    rsv_we_a = 1'b0; rsv_addr_a = '0;
  endtask

  task automatic idle_b();
    raddr_b = '0; we_b = '0; waddr_b = '0; wdata_b = '0;
    rsv_we_b = 1'b0; rsv_addr_b = '0;
  endtask

  // Inputs already driven after a falling edge; predict, compare, advance model.
  task automatic cycle_a();
    logic [4:0]  a;
    logic [31:0] d;
    logic        b;
    for (int i = 0; i < 2; i++) begin
      a = raddr_a[i*5 +: 5];
      d = ma[a];
      b = ba[a];
      for (int j = 0; j < 2; j++) begin
        if (we_a[j] && waddr_a[j*5 +: 5] == a) begin
          d = wdata_a[j*32 +: 32];
          b = 1'b0;
        end
      end
      if (a == 5'd0) begin
        d = '0;
        b = 1'b0;
      end
      q_data.push_back({32'd0, d});
      q_busy.push_back(b);
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("a_rdata%0d_r%0d", i, raddr_a[i*5 +: 5]), {32'd0, rdata_a[i*32 +: 32]}, q_data.pop_front());
      chk($sformatf("a_rbusy%0d_r%0d", i, raddr_a[i*5 +: 5]), {63'd0, rbusy_a[i]}, {63'd0, q_busy.pop_front()});
    end
    if (rst) begin
      for (int k = 0; k < 32; k++) begin
        ma[k] = '0;
        ba[k] = 1'b0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (we_a[j] && waddr_a[j*5 +: 5] != 5'd0) begin
          ma[waddr_a[j*5 +: 5]] = wdata_a[j*32 +: 32];
          ba[waddr_a[j*5 +: 5]] = 1'b0;
        end
      end
      if (rsv_we_a && rsv_addr_a != 5'd0) ba[rsv_addr_a] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic cycle_b();
    logic [3:0]  a;
    logic [63:0] d;
    logic        b;
    for (int i = 0; i < 4; i++) begin
      a = raddr_b[i*4 +: 4];
      d = mb[a];
      b = bb[a];
      if (we_b[0] && waddr_b == a) begin
        d = wdata_b;
        b = 1'b0;
      end
      if (a == 4'd0) begin
        d = '0;
        b = 1'b0;
      end
      q_data.push_back(d);
      q_busy.push_back(b);
    end
    #2;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_rdata%0d", i), rdata_b[i*64 +: 64], q_data.pop_front());
      chk($sformatf("b_rbusy%0d", i), {63'd0, rbusy_b[i]}, {63'd0, q_busy.pop_front()});
    end
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        mb[k] = '0;
        bb[k] = 1'b0;
      end
    end else begin
      if (we_b[0] && waddr_b != 4'd0) begin
        mb[waddr_b] = wdata_b;
        bb[waddr_b] = 1'b0;
      end
      if (rsv_we_b && rsv_addr_b != 4'd0) bb[rsv_addr_b] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle_a();
    idle_b();
    for (int k = 0; k < 32; k++) begin ma[k] = '0; ba[k] = 1'b0; end
    for (int k = 0; k < 16; k++) begin mb[k] = '0; bb[k] = 1'b0; end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Post-reset sweep of every address on both ports
    for (int a = 0; a < 32; a++) begin
      raddr_a = {5'(31 - a), 5'(a)};
      cycle_a();
    end

    // Bypass in the write cycle, storage the next cycle
    idle_a();
    we_a = 2'b01; waddr_a = {5'd0, 5'd5}; wdata_a = {32'd0, 32'hDEADBEEF};
    raddr_a = {5'd5, 5'd0};
    cycle_a();
    idle_a(); raddr_a = {5'd5, 5'd5};
    cycle_a();

    // Writes to r0 are dropped
    idle_a();
    we_a = 2'b10; waddr_a = {5'd0, 5'd0}; wdata_a = {32'h1234, 32'd0};
    cycle_a();
    idle_a();
    cycle_a();

    // Write conflict: port 1 wins
    we_a = 2'b11; waddr_a = {5'd7, 5'd7}; wdata_a = {32'h22, 32'h11};
    raddr_a = {5'd7, 5'd7};
    cycle_a();
    idle_a(); raddr_a = {5'd7, 5'd7};
    cycle_a();

    // Reservation, clear by write, reservation beating write
    idle_a(); rsv_we_a = 1'b1; rsv_addr_a = 5'd9; raddr_a = {5'd9, 5'd9};
    cycle_a();
    idle_a(); raddr_a = {5'd9, 5'd9};
    cycle_a();
    we_a = 2'b01; waddr_a = {5'd0, 5'd9}; wdata_a = {32'd0, 32'h55};
    cycle_a();
    idle_a(); raddr_a = {5'd9, 5'd9};
    cycle_a();
    we_a = 2'b10; waddr_a = {5'd9, 5'd0}; wdata_a = {32'h66, 32'd0};
    rsv_we_a = 1'b1; rsv_addr_a = 5'd9;
    cycle_a();
    idle_a(); raddr_a = {5'd9, 5'd9};
    cycle_a();

    // Reservation of r0 ignored
    idle_a(); rsv_we_a = 1'b1; rsv_addr_a = 5'd0;
    cycle_a();
    idle_a();
    cycle_a();

    // Reset mid-operation discards state
    idle_a(); rsv_we_a = 1'b1; rsv_addr_a = 5'd3;
    cycle_a();
    idle_a(); we_a = 2'b01; waddr_a = {5'd0, 5'd4}; wdata_a = {32'd0, 32'hA5};
    cycle_a();
    idle_a(); raddr_a = {5'd4, 5'd3};
    cycle_a();
    rst = 1'b1; rsv_we_a = 1'b1; rsv_addr_a = 5'd4;
    we_a = 2'b01; waddr_a = {5'd0, 5'd3}; wdata_a = {32'd0, 32'h77};
    cycle_a();
    rst = 1'b0; idle_a(); raddr_a = {5'd4, 5'd3};
    cycle_a();

    // Random traffic on the default geometry
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 99) == 0);
      raddr_a    = 10'($urandom);
      we_a       = 2'($urandom);
      waddr_a    = ($urandom_range(0, 3) == 0) ? {2{5'($urandom_range(0, 3))}} : 10'($urandom);
      wdata_a    = {$urandom, $urandom};
      rsv_we_a   = ($urandom_range(0, 3) == 0);
      rsv_addr_a = 5'($urandom);
      cycle_a();
    end
    rst = 1'b0;
    idle_a();

    // Random traffic on the swept geometry
    for (int n = 0; n < 10000; n++) begin
      rst        = ($urandom_range(0, 499) == 0);
      raddr_b    = 16'($urandom);
      we_b       = 1'($urandom);
      waddr_b    = 4'($urandom);
      wdata_b    = {$urandom, $urandom};
      rsv_we_b   = ($urandom_range(0, 2) == 0);
      rsv_addr_b = ($urandom_range(0, 3) == 0) ? waddr_b : 4'($urandom);
      cycle_b();
    end
    rst = 1'b0;
    idle_b();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
